// File: rtl/rr_pkg.sv
// Shared types and default parameters for the result reader.
package rr_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DW_DEF    = 14;
    localparam int DEPTH_DEF = 8;
    localparam int LAT_DEF   = 2;
    localparam int NCAP_DEF  = 16;
endpackage

// File: rtl/result_reader_if.sv
// Capture-control and read-port bundle between result_reader and its neighbours.
interface result_reader_if #(
    parameter int DW    = rr_pkg::DW_DEF,
    parameter int DEPTH = rr_pkg::DEPTH_DEF
);
    logic                     start;
    logic                     e;
    logic [DW-1:0]            y;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [DW-1:0]            rd_data;
    logic [$clog2(DEPTH):0]   level;
    logic                     busy;
    logic                     done;
    logic                     overflow;

    modport slave (
        input  start, e, y, rd_ready,
        output rd_valid, rd_data, level, busy, done, overflow
    );

    modport master (
        output start, e, y, rd_ready,
        input  rd_valid, rd_data, level, busy, done, overflow
    );
endinterface

// File: rtl/rr_fifo.sv
// Circular-buffer FIFO with registered occupancy; head is read straight from storage.
module rr_fifo #(
    parameter int DW    = 14,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW-1:0]            i_data,
    output logic [DW-1:0]            o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_rd;
    logic          w_wr;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    // A write into a full buffer is only legal when the head leaves the same cycle.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/result_reader.sv
// Captures up to NCAP pipeline results per run into a FIFO and serves them on a read port.
module result_reader
    import rr_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int NCAP  = NCAP_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    result_reader_if.slave bus
);
    localparam int CW = $clog2(NCAP + 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_nxt;
    logic                   r_overflow;
    logic                   w_overflow_nxt;
    logic [LAT-1:0]         r_e_dly;
    logic                   w_vld;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [DW-1:0]          w_head;
    logic [$clog2(DEPTH):0] w_level;

    // Oldest tap marks the cycle in which y belongs to an enabled operand set.
    assign w_vld = r_e_dly[LAT-1];
    assign w_pop = !w_empty && bus.rd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_e_dly    <= '0;
            r_state    <= IDLE;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_e_dly[0] <= bus.e;
            for (int i = 1; i < LAT; i++) r_e_dly[i] <= r_e_dly[i-1];
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_push         = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt    = CAPTURE;
                    w_count_nxt    = '0;
                    w_overflow_nxt = 1'b0;
                end
            end
            CAPTURE: begin
                // A restart wins over a result arriving in the same cycle.
                if (bus.start) begin
                    w_count_nxt    = '0;
                    w_overflow_nxt = 1'b0;
                end else if (w_vld) begin
                    w_count_nxt = r_count + 1'b1;
                    if (!w_full || w_pop) w_push = 1'b1;
                    else                  w_overflow_nxt = 1'b1;
                    if (r_count == CW'(NCAP - 1)) w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    rr_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (bus.rd_ready),
        .i_data  (bus.y),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign bus.rd_valid = !w_empty;
    assign bus.rd_data  = w_head;
    assign bus.level    = w_level;
    assign bus.busy     = (r_state == CAPTURE);
    assign bus.done     = (r_state == DONE);
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: queue-based reference model, negedge monitor.
module tb_result_reader;
    localparam int DW    = 14;
    localparam int DEPTH = 8;
    localparam int LAT   = 2;
    localparam int NCAP  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_reader_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    result_reader #(.DW(DW), .DEPTH(DEPTH), .LAT(LAT), .NCAP(NCAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int peak   = 0;
    int n_pop  = 0;

    // Reference model state
    int            m_level   = 0;
    int            m_taken   = 0;
    bit            m_running = 0;
    bit            m_done    = 0;
    bit            m_ovf     = 0;
    bit            m_ehist[$];
    logic [DW-1:0] sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit vld, pop, push;
        if (!rst_n) begin
            m_level = 0; m_taken = 0; m_running = 0; m_done = 0; m_ovf = 0;
            m_ehist.delete();
            for (int i = 0; i < LAT; i++) m_ehist.push_back(1'b0);
            sb_q.delete();
        end else begin
            vld = m_ehist.pop_front();
            m_ehist.push_back(bus.e);
            pop  = (m_level > 0) && bus.rd_ready;
            push = 0;
            if (bus.start) begin
                m_running = 1; m_done = 0; m_ovf = 0; m_taken = 0;
            end else if (m_running && vld) begin
                m_taken++;
                if (m_level < DEPTH || pop) push = 1;
                else                        m_ovf = 1;
                if (m_taken == NCAP) begin m_running = 0; m_done = 1; end
            end
            if (push) sb_q.push_back(bus.y);
            m_level = m_level + int'(push) - int'(pop);
        end
    end

    always @(negedge clk) begin : monitor
        chk("level",    bus.level,    m_level);
        chk("rd_valid", bus.rd_valid, m_level > 0);
        chk("busy",     bus.busy,     m_running);
        chk("done",     bus.done,     m_done);
        chk("overflow", bus.overflow, m_ovf);
        if (int'(bus.level) > peak) peak = int'(bus.level);
        if (bus.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_data actual=%0h required=<none, scoreboard empty>", bus.rd_data);
            end else begin
                chk("rd_data", bus.rd_data, sb_q[0]);
                if (bus.rd_ready) begin
                    void'(sb_q.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic drive(input bit st, input bit ev, input bit rdy, input logic [DW-1:0] yv);
        bus.start    = st;
        bus.e        = ev;
        bus.rd_ready = rdy;
        bus.y        = yv;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ry();
        return DW'($urandom);
    endfunction

    logic [DW-1:0] vals [4];
    bit            pat  [6];

    initial begin
        vals = '{14'h0EB1, 14'h0001, 14'h3FFF, 14'h0000};
        pat  = '{1, 0, 1, 1, 0, 1};

        // Reset held with e high
        rst_n = 1'b0;
        repeat (3) drive(0, 1, 0, ry());
        chk("rst_level",    bus.level,    0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_done",     bus.done,     0);
        chk("rst_overflow", bus.overflow, 0);
        rst_n = 1'b1;
        repeat (LAT + 1) drive(0, 1, 1, ry());
        chk("post_rst_level", bus.level, 0);
        drive(0, 0, 1, ry());

        // Four directed values with streaming reads
        peak = 0;
        drive(1, 0, 1, ry());
        for (int i = 0; i < 4 + LAT; i++)
            drive(0, i < 4, 1, (i >= LAT) ? vals[i-LAT] : ry());
        repeat (4) drive(0, 0, 1, ry());
        chk("t2_peak", peak, 1);
        chk("t2_done", bus.done, 0);

        // Overflow run: 16 results, reader stalled
        drive(1, 0, 0, ry());
        repeat (16) drive(0, 1, 0, ry());
        repeat (LAT + 1) drive(0, 0, 0, ry());
        chk("t3_level",    bus.level,    DEPTH);
        chk("t3_overflow", bus.overflow, 1);
        chk("t3_done",     bus.done,     1);

        // Full FIFO with simultaneous push and pop across pointer wrap
        drive(1, 1, 0, ry());
        drive(0, 1, 0, ry());
        repeat (14) drive(0, 1, 1, ry());
        chk("t4_level",    bus.level,    DEPTH);
        chk("t4_overflow", bus.overflow, 0);
        chk("t4_busy",     bus.busy,     1);
        repeat (DEPTH + 4) drive(0, 0, 1, ry());

        // Sparse enables, irregular reader
        n_pop = 0;
        drive(1, 0, 0, ry());
        for (int i = 0; i < 6; i++) drive(0, pat[i], $urandom_range(0, 1), ry());
        repeat (30) drive(0, 0, ($urandom % 3) == 0, ry());
        repeat (DEPTH) drive(0, 0, 1, ry());
        chk("t5_captures", n_pop, 4);

        // Reset mid-run with five entries buffered
        drive(1, 0, 0, ry());
        repeat (5) drive(0, 1, 0, ry());
        repeat (LAT) drive(0, 0, 0, ry());
        chk("t6_level_pre", bus.level, 5);
        rst_n = 1'b0;
        drive(0, 1, 0, ry());
        rst_n = 1'b1;
        chk("t6_level",    bus.level,    0);
        chk("t6_busy",     bus.busy,     0);
        chk("t6_rd_valid", bus.rd_valid, 0);
        drive(1, 0, 1, ry());
        repeat (6) drive(0, 1, 1, ry());

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n = (($urandom % 250) != 0);
            drive(($urandom % 40) == 0, $urandom_range(0, 1), ($urandom % 3) != 0, ry());
        end
        rst_n = 1'b1;
        repeat (DEPTH + LAT + 2) drive(0, 0, 1, ry());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
